dram_controller_fsm: RTL and testbench



---
 rtl/dram_controller_fsm.sv | 174 +++++++++++++++++
 tb/tb_dram_controller_fsm.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_controller_fsm.sv
// FPM DRAM controller for a 32-bit 68030 port: row/column multiplexing, per-bank RAS,
// per-lane CAS, DSACK generation and periodic CAS-before-RAS refresh.
module dram_controller_fsm #(
    parameter int ADDR_W      = 12,
    parameter int BANKS       = 4,
    parameter int T_RCD       = 1,
    parameter int T_CAS       = 2,
    parameter int T_RP        = 2,
    parameter int T_REF_RAS   = 3,
    parameter int REFRESH_DIV = 780
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              CS_n,
    input  logic              AS_n,
    input  logic              DS_n,
    input  logic              RW,
    input  logic              SIZ0,
    input  logic              SIZ1,
    input  logic [27:0]       ADDR,
    output logic [ADDR_W-1:0] ADDR_DRAM,
    output logic [BANKS-1:0]  RAS_n,
    output logic [3:0]        CAS_n,
    output logic              DRAM_WR_n,
    output logic              DSACK0_DRAM_n,
    output logic              DSACK1_DRAM_n
);

    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int TMR_W  = 8;

    localparam logic [TMR_W-1:0] RCD_LAST = TMR_W'(T_RCD - 1);
    localparam logic [TMR_W-1:0] CAS_LAST = TMR_W'(T_CAS - 1);
    localparam logic [TMR_W-1:0] RP_LAST  = TMR_W'(T_RP - 1);
    localparam logic [TMR_W-1:0] REF_LAST = TMR_W'(T_REF_RAS - 1);
    localparam logic [REF_W-1:0] DIV_LAST = REF_W'(REFRESH_DIV - 1);

    typedef enum logic [2:0] {IDLE, ROW, COL, ACK, PRE, REF_CAS, REF_RAS} state_t;

    state_t            state, state_next;
    logic [TMR_W-1:0]  tmr;
    logic [REF_W-1:0]  ref_cnt;
    logic              ref_pending;
    logic [BANK_W-1:0] addr_bank, bank_l;
    logic [ADDR_W-1:0] row_l, col_l, addr_d;
    logic [3:0]        lanes_l, cas_d;
    logic [BANKS-1:0]  ras_d;
    logic              rw_l, wr_d, ack_d;

    // Active-low lane enables; lane 0 is D31:24, so offset 0 maps to bit 0.
    function automatic logic [3:0] lane_cas_n(input logic rw, input logic [1:0] siz,
                                              input logic [1:0] off);
        logic [2:0] last;
        logic [3:0] cas_n;
        last = {1'b0, off} + ((siz == 2'b00) ? 3'd3 : ({1'b0, siz} - 3'd1));
        for (int i = 0; i < 4; i++)
            cas_n[i] = !(rw || ((3'(i) >= {1'b0, off}) && (3'(i) <= last)));
        return cas_n;
    endfunction

    generate
        if (BANKS > 1) begin : g_bank
            assign addr_bank = ADDR[2*ADDR_W+2 +: BANK_W];
        end else begin : g_nobank
            assign addr_bank = '0;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state         <= IDLE;
            tmr           <= '0;
            RAS_n         <= '1;
            CAS_n         <= '1;
            DRAM_WR_n     <= 1'b1;
            DSACK0_DRAM_n <= 1'b1;
            DSACK1_DRAM_n <= 1'b1;
            ADDR_DRAM     <= '0;
        end else begin
            state         <= state_next;
            tmr           <= (state_next != state) ? '0 : ((tmr == '1) ? tmr : tmr + 1'b1);
            RAS_n         <= ras_d;
            CAS_n         <= cas_d;
            DRAM_WR_n     <= wr_d;
            DSACK0_DRAM_n <= ack_d;
            DSACK1_DRAM_n <= ack_d;
            ADDR_DRAM     <= addr_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ref_pending)
                    state_next = REF_CAS;
                else if (!CS_n && !AS_n)
                    state_next = ROW;
            end
            ROW: begin
                if (AS_n)
                    state_next = PRE;
                else if ((tmr >= RCD_LAST) && (rw_l || !DS_n))
                    state_next = COL;
            end
            COL: begin
                if (AS_n)
                    state_next = PRE;
                else if (tmr >= CAS_LAST)
                    state_next = ACK;
            end
            ACK:     if (AS_n) state_next = PRE;
            PRE:     if (tmr >= RP_LAST) state_next = IDLE;
            REF_CAS: state_next = REF_RAS;
            REF_RAS: if (tmr >= REF_LAST) state_next = PRE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the current state and registered, so they lag state by one edge.
    always_comb begin
        ras_d  = '1;
        cas_d  = '1;
        wr_d   = 1'b1;
        ack_d  = 1'b1;
        addr_d = ADDR_DRAM;
        case (state)
            ROW: begin
                ras_d  = ~(BANKS'(1) << bank_l);
                addr_d = row_l;
                wr_d   = rw_l;
            end
            COL, ACK: begin
                ras_d  = ~(BANKS'(1) << bank_l);
                cas_d  = lanes_l;
                addr_d = col_l;
                wr_d   = rw_l;
                ack_d  = (state != ACK);
            end
            REF_CAS: cas_d = '0;
            REF_RAS: begin
                ras_d = '0;
                cas_d = '0;
            end
            default: ;
        endcase
    end

    // A wrap that lands while a request is already pending is dropped.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            ref_cnt     <= '0;
            ref_pending <= 1'b0;
        end else begin
            ref_cnt <= (ref_cnt == DIV_LAST) ? '0 : ref_cnt + 1'b1;
            if (state == IDLE && state_next == REF_CAS)
                ref_pending <= 1'b0;
            else if (ref_cnt == DIV_LAST)
                ref_pending <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (state == IDLE && state_next == ROW) begin
            bank_l  <= addr_bank;
            row_l   <= ADDR[2*ADDR_W+1:ADDR_W+2];
            col_l   <= ADDR[ADDR_W+1:2];
            lanes_l <= lane_cas_n(RW, {SIZ1, SIZ0}, ADDR[1:0]);
            rw_l    <= RW;
        end
    end

endmodule

// File: tb/tb_dram_controller_fsm.sv
// Scoreboard bench: a cycle-numbered timeline model predicts every bus event,
// a negedge monitor detects events on the DRAM outputs and pops/compares them.
module tb_dram_controller_fsm;

    localparam int AW = 12, NB = 4, TRCD = 1, TCAS = 2, TRP = 2, TREF = 3, RDIV = 16;
    localparam int K_ROW = 0, K_COL = 1, K_ACK = 2, K_REF = 3, K_END = 4;

    typedef struct {
        int kind;
        int at;
        int ras;
        int cas;
        int wr;
        int ad;
    } ev_t;

    logic          clk = 0, rst_n = 0;
    logic          cs_n = 1, as_n = 1, ds_n = 1, rw = 1, siz0 = 0, siz1 = 0;
    logic [27:0]   addr = '0;
    logic [AW-1:0] addr_dram;
    logic [NB-1:0] ras_n;
    logic [3:0]    cas_n;
    logic          wr_n, dsack0_n, dsack1_n;

    int   cyc = 0;
    int   total = 0, bad = 0;
    int   free_e = 1, last_clr = 0;
    int   mon_limit = 32'h7fffffff;
    ev_t  accq[$];
    ev_t  refq[$];

    dram_controller_fsm #(.ADDR_W(AW), .BANKS(NB), .T_RCD(TRCD), .T_CAS(TCAS), .T_RP(TRP),
                          .T_REF_RAS(TREF), .REFRESH_DIV(RDIV)) dut (
        .CLK(clk), .RST_n(rst_n), .CS_n(cs_n), .AS_n(as_n), .DS_n(ds_n), .RW(rw),
        .SIZ0(siz0), .SIZ1(siz1), .ADDR(addr), .ADDR_DRAM(addr_dram), .RAS_n(ras_n),
        .CAS_n(cas_n), .DRAM_WR_n(wr_n), .DSACK0_DRAM_n(dsack0_n), .DSACK1_DRAM_n(dsack1_n)
    );

    always #5 clk = ~clk;

    // Edge number n = n-th rising edge since reset was released.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h (edge %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic int exp_cas(input bit r, input int sz, input int o);
        int n, m;
        n = (sz == 0) ? 4 : sz;
        m = 0;
        for (int b = 0; b < 4; b++)
            if (!(r || (b >= o && b < o + n))) m |= (1 << b);
        return m;
    endfunction

    function automatic bit pending_at(input int e);
        return ((last_clr / RDIV + 1) * RDIV) < e;
    endfunction

    task automatic model_refresh();
        ev_t e;
        e = '{K_REF, free_e + 1, 'hF, 0, 1, 0};
        refq.push_back(e);
        last_clr = free_e;
        free_e   = free_e + 1 + TREF + TRP + 1;
    endtask

    // Advance the idle controller through every edge before lim with no access present.
    task automatic model_idle_until(input int lim);
        while (free_e < lim) begin
            if (pending_at(free_e)) model_refresh();
            else free_e++;
        end
    endtask

    task automatic model_accept(input int a, output int k);
        model_idle_until(a);
        k = -1;
        while (k < 0) begin
            if (pending_at(free_e)) model_refresh();
            else k = free_e;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            model_idle_until(cyc + 2);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_xfer(input logic [27:0] ad, input bit r, input int sz, input int dsd,
                           input bit abort, input bit hold);
        int  a, k, c, bank, t;
        ev_t e;
        a    = cyc + 1;
        addr = ad; rw = r; {siz1, siz0} = 2'(sz); cs_n = 0; as_n = 0;
        ds_n = (r || (!abort && dsd == 0)) ? 1'b0 : 1'b1;
        model_accept(a, k);
        bank = (int'(ad) >> (2*AW + 2)) & (NB - 1);
        e = '{K_ROW, k + 1, 'hF & ~(1 << bank), 'hF, r, (int'(ad) >> (AW + 2)) & ((1 << AW) - 1)};
        accq.push_back(e);
        if (abort) begin
            for (t = 0; t < 200 && cyc < k + 1; t++) begin @(posedge clk); #1; end
        end else begin
            c = r ? k + TRCD : ((k + TRCD > a + dsd) ? k + TRCD : a + dsd);
            e.kind = K_COL; e.at = c + 1; e.cas = exp_cas(r, sz, int'(ad) & 3);
            e.ad   = (int'(ad) >> 2) & ((1 << AW) - 1);
            accq.push_back(e);
            e.kind = K_ACK; e.at = c + TCAS + 1;
            accq.push_back(e);
            for (t = 0; t < 200; t++) begin
                @(posedge clk); #1;
                if (cyc == a - 1 + dsd) ds_n = 0;
                if (!dsack0_n) break;
            end
            chk("dsack_seen", int'(dsack0_n), 0);
            if (hold) return;
        end
        as_n = 1; cs_n = 1; ds_n = 1;
        e.kind = K_END; e.at = cyc + 2; e.wr = 1; e.cas = 'hF;
        accq.push_back(e);
        free_e = cyc + 1 + TRP + 1;
    endtask

    task automatic got_ev(input int kind);
        ev_t e;
        if (cyc > mon_limit) return;
        if (kind == K_REF) begin
            if (refq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_refresh at edge %0d (none expected)", cyc);
                return;
            end
            e = refq.pop_front();
            chk("ref_edge", cyc, e.at);
            chk("ref_wr", int'(wr_n), 1);
            return;
        end
        if (accq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_event kind=%0d at edge %0d (none expected)", kind, cyc);
            return;
        end
        e = accq.pop_front();
        chk("ev_kind", kind, e.kind);
        if (kind != e.kind) return;
        chk("ev_edge", cyc, e.at);
        case (kind)
            K_ROW: begin
                chk("row_ras", int'(ras_n), e.ras);
                chk("row_addr", int'(addr_dram), e.ad);
                chk("row_wr", int'(wr_n), e.wr);
            end
            K_COL: begin
                chk("col_ras", int'(ras_n), e.ras);
                chk("col_cas", int'(cas_n), e.cas);
                chk("col_addr", int'(addr_dram), e.ad);
                chk("col_wr", int'(wr_n), e.wr);
            end
            K_ACK:   chk("ack_dsack1", int'(dsack1_n), 0);
            default: begin
                chk("end_cas", int'(cas_n), 'hF);
                chk("end_wr", int'(wr_n), 1);
                chk("end_dsack", int'(dsack0_n), 1);
            end
        endcase
    endtask

    logic [NB-1:0] p_ras = '1;
    logic [3:0]    p_cas = '1;
    logic          p_ack = 1;

    always @(negedge clk) begin
        chk("dsack_pair", int'(dsack0_n), int'(dsack1_n));
        if (rst_n) begin
            if (p_ras == '1 && p_cas == '1 && ras_n != '1 && cas_n == '1) got_ev(K_ROW);
            if (p_cas == '1 && p_ras != '1 && cas_n != '1) got_ev(K_COL);
            if (p_ack && !dsack0_n) got_ev(K_ACK);
            if (p_ras == '1 && ras_n == '1 && cas_n == '0) got_ev(K_REF);
            if (p_ras != '1 && p_ras != '0 && ras_n == '1 && cas_n == '1) got_ev(K_END);
        end
        p_ras = ras_n;
        p_cas = cas_n;
        p_ack = dsack0_n;
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_ras"}, int'(ras_n), 'hF);
        chk({tag, "_cas"}, int'(cas_n), 'hF);
        chk({tag, "_wr"}, int'(wr_n), 1);
        chk({tag, "_dsack0"}, int'(dsack0_n), 1);
        chk({tag, "_dsack1"}, int'(dsack1_n), 1);
        chk({tag, "_addr"}, int'(addr_dram), 0);
    endtask

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1;
        free_e = 1; last_clr = 0;
        idle(2);

        do_xfer(28'h0000008, 1, 0, 0, 0, 0);
        idle(1);
        do_xfer(28'h8000003, 0, 1, 3, 0, 0);
        idle(2);
        do_xfer(28'h4000002, 0, 2, 1, 0, 0);
        idle(1);
        do_xfer(28'h0000006, 0, 3, 0, 0, 0);
        idle(1);
        do_xfer(28'hC001234, 0, 0, 0, 1, 0);
        idle(1);

        // Address strobe outside the DRAM region must be ignored.
        cs_n = 1; as_n = 0;
        idle(4);
        as_n = 1;

        idle(40);

        w = (cyc / RDIV + 1) * RDIV;
        if (w < cyc + 2) w += RDIV;
        idle(w - cyc);
        do_xfer(28'h0000104, 1, 0, 0, 0, 0);
        idle(2);

        for (int i = 0; i < 30; i++) begin
            logic [27:0] ad;
            bit          r, ab;
            ad = 28'($urandom);
            r  = 1'($urandom_range(0, 1));
            ab = !r && ($urandom_range(0, 5) == 0);
            do_xfer(ad, r, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ab, 0);
            idle(int'($urandom_range(1, 4)));
        end

        do_xfer(28'h0000010, 1, 0, 0, 0, 1);
        @(negedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        chk_reset("mid_ack_reset");
        repeat (2) @(posedge clk);
        #1;
        chk_reset("held_reset");
        as_n = 1; cs_n = 1; ds_n = 1;
        rst_n = 1;
        free_e = 1; last_clr = 0;
        idle(3);
        do_xfer(28'h4000020, 0, 0, 0, 0, 0);
        idle(20);

        model_idle_until(cyc + 2);
        mon_limit = cyc + 2;
        repeat (4) @(posedge clk);
        #1;
        chk("acc_queue_drained", accq.size(), 0);
        chk("ref_queue_drained", refq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
